// File: rtl/spi_ram_burst.sv
// Command-decoded single-port RAM fed by the SPI slave receive stream.
// Address/data commands arm write or read paths; optional burst post-increment.
module spi_ram_burst #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AUTO_INC   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH+1:0] din,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  output logic                  cmd_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WR_ARMED,
    RD_ARMED
  } state_t;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  state_t                r_state;
  state_t                w_next_state;
  cmd_t                  w_cmd;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_tx_valid;
  logic                  r_cmd_err;
  logic                  w_ld_wr;
  logic                  w_ld_rd;
  logic                  w_we;
  logic                  w_re;
  logic                  w_err;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  assign w_cmd = cmd_t'(din[DATA_WIDTH+1:DATA_WIDTH]);

  always_comb begin
    w_next_state = r_state;
    w_ld_wr      = 1'b0;
    w_ld_rd      = 1'b0;
    w_we         = 1'b0;
    w_re         = 1'b0;
    w_err        = 1'b0;
    if (rx_valid) begin
      unique case (r_state)
        IDLE: begin
          unique case (w_cmd)
            CMD_WR_ADDR: begin
              w_ld_wr      = 1'b1;
              w_next_state = WR_ARMED;
            end
            CMD_RD_ADDR: begin
              w_ld_rd      = 1'b1;
              w_next_state = RD_ARMED;
            end
            default: w_err = 1'b1;
          endcase
        end
        WR_ARMED: begin
          unique case (w_cmd)
            CMD_WR_DATA: begin
              w_we = 1'b1;
              if (AUTO_INC == 0) w_next_state = IDLE;
            end
            CMD_WR_ADDR: w_ld_wr = 1'b1;
            CMD_RD_ADDR: begin
              w_ld_rd      = 1'b1;
              w_next_state = RD_ARMED;
            end
            default: w_err = 1'b1;
          endcase
        end
        RD_ARMED: begin
          unique case (w_cmd)
            CMD_RD_DATA: begin
              w_re = 1'b1;
              if (AUTO_INC == 0) w_next_state = IDLE;
            end
            CMD_RD_ADDR: w_ld_rd = 1'b1;
            CMD_WR_ADDR: begin
              w_ld_wr      = 1'b1;
              w_next_state = WR_ARMED;
            end
            default: w_err = 1'b1;
          endcase
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_dout     <= '0;
      r_tx_valid <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_tx_valid <= w_re;
      r_cmd_err  <= w_err;
      if (w_ld_wr)
        r_wr_addr <= din[ADDR_WIDTH-1:0];
      else if (w_we && AUTO_INC != 0)
        r_wr_addr <= r_wr_addr + 1'b1;
      if (w_ld_rd)
        r_rd_addr <= din[ADDR_WIDTH-1:0];
      else if (w_re && AUTO_INC != 0)
        r_rd_addr <= r_rd_addr + 1'b1;
      if (w_re)
        r_dout <= r_mem[r_rd_addr];
    end
  end

  // Storage has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wr_addr] <= din[DATA_WIDTH-1:0];
  end

  assign dout     = r_dout;
  assign tx_valid = r_tx_valid;
  assign cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Self-checking bench: burst, single-shot and wide instances against a command-level model.
module tb_spi_ram_burst;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  din_a, din_b;
  logic [17:0] din_c;
  logic        rxv_a, rxv_b, rxv_c;
  logic [7:0]  dout_a, dout_b;
  logic [15:0] dout_c;
  logic        tx_a, tx_b, tx_c;
  logic        err_a, err_b, err_c;

  int errors = 0;
  int checks = 0;

  // index 0 = 8-bit burst, 1 = 8-bit single-shot, 2 = 16-bit data / 10-bit address burst
  int aw[3] = '{8, 8, 10};
  int dw[3] = '{8, 8, 16};
  int ai[3] = '{1, 0, 1};
  int m_st[3];
  int m_wa[3];
  int m_ra[3];
  int m_dout[3];
  int e_tx[3];
  int e_err[3];
  int m_mem[3][1024];

  always #5 clk = ~clk;

  spi_ram_burst #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .AUTO_INC(1)) u_burst (
    .clk(clk), .rst_n(rst_n), .din(din_a), .rx_valid(rxv_a),
    .dout(dout_a), .tx_valid(tx_a), .cmd_err(err_a));

  spi_ram_burst #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .AUTO_INC(0)) u_single (
    .clk(clk), .rst_n(rst_n), .din(din_b), .rx_valid(rxv_b),
    .dout(dout_b), .tx_valid(tx_b), .cmd_err(err_b));

  spi_ram_burst #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .AUTO_INC(1)) u_wide (
    .clk(clk), .rst_n(rst_n), .din(din_c), .rx_valid(rxv_c),
    .dout(dout_c), .tx_valid(tx_c), .cmd_err(err_c));

  function automatic void reset_model();
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_wa[k] = 0; m_ra[k] = 0;
      m_dout[k] = 0; e_tx[k] = 0; e_err[k] = 0;
    end
  endfunction

  // Mode 0 = idle, 1 = write armed, 2 = read armed
  function automatic void apply(int k, int cmd, int pay);
    int amask = (1 << aw[k]) - 1;
    int a = pay & amask;
    int v = pay & ((1 << dw[k]) - 1);
    e_tx[k] = 0;
    e_err[k] = 0;
    if (m_st[k] == 0) begin
      if (cmd == 0) begin m_wa[k] = a; m_st[k] = 1; end
      else if (cmd == 2) begin m_ra[k] = a; m_st[k] = 2; end
      else e_err[k] = 1;
    end else if (m_st[k] == 1) begin
      if (cmd == 1) begin
        m_mem[k][m_wa[k]] = v;
        if (ai[k] != 0) m_wa[k] = (m_wa[k] + 1) & amask; else m_st[k] = 0;
      end else if (cmd == 0) m_wa[k] = a;
      else if (cmd == 2) begin m_ra[k] = a; m_st[k] = 2; end
      else e_err[k] = 1;
    end else begin
      if (cmd == 3) begin
        m_dout[k] = m_mem[k][m_ra[k]];
        e_tx[k] = 1;
        if (ai[k] != 0) m_ra[k] = (m_ra[k] + 1) & amask; else m_st[k] = 0;
      end else if (cmd == 2) m_ra[k] = a;
      else if (cmd == 0) begin m_wa[k] = a; m_st[k] = 1; end
      else e_err[k] = 1;
    end
  endfunction

  function automatic logic [15:0] obs_dout(int k);
    case (k)
      0:       return {8'h00, dout_a};
      1:       return {8'h00, dout_b};
      default: return dout_c;
    endcase
  endfunction

  function automatic logic obs_tx(int k);
    case (k)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic obs_err(int k);
    case (k)
      0:       return err_a;
      1:       return err_b;
      default: return err_c;
    endcase
  endfunction

  task automatic cmp(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d] actual=%0h required=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      cmp("dout", k, obs_dout(k), 16'(m_dout[k]));
      cmp("tx_valid", k, {15'b0, obs_tx(k)}, 16'(e_tx[k]));
      cmp("cmd_err", k, {15'b0, obs_err(k)}, 16'(e_err[k]));
    end
  endtask

  task automatic send(input int d, input int cmd, input int pay);
    rxv_a = 1'b0; rxv_b = 1'b0; rxv_c = 1'b0;
    case (d)
      0: begin din_a = {cmd[1:0], pay[7:0]};  rxv_a = 1'b1; end
      1: begin din_b = {cmd[1:0], pay[7:0]};  rxv_b = 1'b1; end
      default: begin din_c = {cmd[1:0], pay[15:0]}; rxv_c = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k == d) apply(k, cmd, pay);
      else begin e_tx[k] = 0; e_err[k] = 0; end
    end
    check_all();
  endtask

  task automatic idle();
    rxv_a = 1'b0; rxv_b = 1'b0; rxv_c = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin e_tx[k] = 0; e_err[k] = 0; end
    check_all();
  endtask

  initial begin
    rxv_a = 1'b0; rxv_b = 1'b0; rxv_c = 1'b0;
    din_a = '0; din_b = '0; din_c = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    reset_model();
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Fill every location so all later reads have known contents
    send(0, 0, 0);
    for (int i = 0; i < 256; i++) send(0, 1, int'($urandom_range(0, 255)));
    for (int i = 0; i < 256; i++) begin
      send(1, 0, i);
      send(1, 1, int'($urandom_range(0, 255)));
    end
    send(2, 0, 0);
    for (int i = 0; i < 1024; i++) send(2, 1, int'($urandom_range(0, 65535)));
    idle();

    // Basic write then read
    send(0, 0, 'h10); send(0, 1, 'hA5); send(0, 2, 'h10); send(0, 3, 0);
    cmp("basic_dout", 0, obs_dout(0), 16'h00A5);
    idle();

    // Burst with address wrap, back-to-back reads
    send(0, 0, 'hFE); send(0, 1, 'h11); send(0, 1, 'h22); send(0, 1, 'h33);
    send(0, 2, 'hFE);
    send(0, 3, 0); cmp("wrap_rd0", 0, obs_dout(0), 16'h0011);
    send(0, 3, 0); cmp("wrap_rd1", 0, obs_dout(0), 16'h0022);
    send(0, 3, 0); cmp("wrap_rd2", 0, obs_dout(0), 16'h0033);
    idle();

    // Single-shot: second data write is illegal
    send(1, 0, 'h05); send(1, 1, 'h77); send(1, 1, 'h88);
    cmp("single_err", 1, {15'b0, obs_err(1)}, 16'h0001);
    send(1, 2, 'h05); send(1, 3, 0);
    cmp("single_dout", 1, obs_dout(1), 16'h0077);

    // Illegal commands from idle, back to back, then memory untouched
    send(1, 1, 'h99); send(1, 3, 0);
    send(1, 2, 'h99); send(1, 3, 0);
    idle();

    // Wide instance, plus upper payload bits ignored on address
    send(2, 0, 'h3FF); send(2, 1, 'hBEEF); send(2, 2, 'h3FF); send(2, 3, 0);
    cmp("wide_dout", 2, obs_dout(2), 16'hBEEF);
    send(2, 0, 'hFC05); send(2, 1, 'h1234); send(2, 2, 'h0005); send(2, 3, 0);
    cmp("wide_mask", 2, obs_dout(2), 16'h1234);
    idle();

    // Reset mid read-burst
    send(0, 2, 'h20); send(0, 3, 0);
    rxv_a = 1'b0; rxv_b = 1'b0; rxv_c = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    reset_model();
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    send(0, 3, 0);
    send(0, 2, 'h20); send(0, 3, 0);
    idle();

    // Randomised command stream across all instances
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) idle();
      else send(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom));
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_ram_burst.md
# spi_ram_burst

Parametrised single-port command-decoded RAM behind the SPI slave front end. Consumes (command, payload) words from the SPI slave's `rx_valid`/`din` stream and performs write-address, write-data, read-address and read-data operations. Optional address auto-increment supports burst writes and reads, and illegal command sequences are flagged. Read data and `tx_valid` go back to the SPI slave for shift-out.

## Interface
- `ADDR_WIDTH`, 8: address bits; memory depth is 2**ADDR_WIDTH words; must be ≤ DATA_WIDTH.
- `DATA_WIDTH`, 8: word width; payload field width of `din`.
- `AUTO_INC`, 1: 1 = burst mode (address post-increment, stay armed); 0 = single-shot mode (no increment, return to IDLE after each data op).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `din`  in  DATA_WIDTH+2  bits [DATA_WIDTH+1:DATA_WIDTH] = command, bits [DATA_WIDTH-1:0] = payload; address uses payload[ADDR_WIDTH-1:0].
- `rx_valid`  in  1  `din` valid this cycle; one command per asserted cycle.
- `dout`  out  DATA_WIDTH  read data, held until next successful read.
- `tx_valid`  out  1  one-cycle pulse: `dout` updated this cycle.
- `cmd_err`  out  1  one-cycle pulse: illegal command for the current state.

## Operation
- Commands:
  - 00 = WR_ADDR: load `wr_addr`.
  - 01 = WR_DATA: write `MEM[wr_addr]`.
  - 10 = RD_ADDR: load `rd_addr`.
  - 11 = RD_DATA: `dout <= MEM[rd_addr]`.
- States: IDLE, WR_ARMED, RD_ARMED. Nothing happens when `rx_valid`=0.
- IDLE:
  - 00 -> load `wr_addr`, go to WR_ARMED.
  - 10 -> load `rd_addr`, go to RD_ARMED.
  - 01 or 11 -> `cmd_err`; state and memory unchanged.
- WR_ARMED:
  - 01 -> write memory. If AUTO_INC: `wr_addr` += 1 (mod 2**ADDR_WIDTH) and stay. Else go to IDLE.
  - 00 -> reload `wr_addr`, stay.
  - 10 -> load `rd_addr`, go to RD_ARMED (write burst abandoned, no error).
  - 11 -> `cmd_err`, no change.
- RD_ARMED:
  - 11 -> read, `tx_valid` pulse. If AUTO_INC: `rd_addr` += 1 (wrap) and stay. Else go to IDLE.
  - 10 -> reload `rd_addr`, stay.
  - 00 -> load `wr_addr`, go to WR_ARMED.
  - 01 -> `cmd_err`, no change.
- Address wrap: all-ones increments to 0 with no flag.
- Unused payload bits above ADDR_WIDTH are ignored for address commands.
- Memory is not reset. Contents survive `rst_n`.

## Timing
- Reset values (async, immediate on `rst_n`=0):
  - `dout`=0, `tx_valid`=0, `cmd_err`=0.
  - state=IDLE, `wr_addr`=0, `rd_addr`=0.
- All outputs are registered.
- RD_DATA sampled at edge N: `dout` and `tx_valid`=1 are valid after edge N; `tx_valid` drops after edge N+1 unless another RD_DATA is sampled at N+1.
- Back-to-back RD_DATA in burst mode: one word per cycle, with `tx_valid` held high continuously.
- WR_DATA at edge N followed by RD_DATA of the same address at N+1 returns the new data (write-before-read ordering across cycles).
- `cmd_err` is a one-cycle pulse per illegal command. Back-to-back illegal commands hold it high.
- Reset asserted mid-burst aborts the burst. The first command after release is decoded from IDLE.
- `rst_n` deassertion is synchronised externally. No command is accepted on the deassertion edge.

## Test plan
- Reset, then write 00/0x10, 01/0xA5, read 10/0x10, 11 -> `dout`=0xA5, `tx_valid` one cycle, `cmd_err` never asserted.
- AUTO_INC=1: 00/0xFE, 01/0x11, 01/0x22, 01/0x33, then 10/0xFE, 11×3 on consecutive cycles -> `dout` 0x11, 0x22, 0x33 (address wraps 0xFF->0x00), `tx_valid` high 3 cycles.
- AUTO_INC=0: 00/0x05, 01/0x77, 01/0x88 -> second 01 raises `cmd_err`; reading 0x05 returns 0x77.
- Illegal from IDLE: 01/0x99 then 11 -> two `cmd_err` pulses, `tx_valid` stays 0, `dout` unchanged, memory unchanged.
- Reset mid-read-burst: 10/0x20, 11, assert `rst_n`=0 -> `dout`=0 and `tx_valid`=0 immediately; after release, 11 gives `cmd_err` and 10/0x20, 11 returns pre-reset memory data.
- DATA_WIDTH=16, ADDR_WIDTH=10: 00/0x3FF, 01/0xBEEF, 10/0x3FF, 11 -> `dout`=0xBEEF.
